// File: rtl/gbc_header_parser.sv
// Purpose: reads the GBC cartridge header and registers the mapper configuration word (GBC_HEADER_CHECKSUM_EN adds checksum verification).
// Latency: 2 enabled cycles per header byte; Done rises 2N+2 enabled cycles after Start (N = 26 with checksum, 7 without).
// Backpressure: one read outstanding; ReadReq/ReadAddr held until ReadAck or until TIMEOUT enabled cycles expire.
module gbc_header_parser #(
    parameter int ADDR_W  = 23,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ClkEn,
    input  logic              Start,
    output logic              ReadReq,
    output logic [ADDR_W-1:0] ReadAddr,
    input  logic              ReadAck,
    input  logic [7:0]        ReadData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              ChecksumOk,
    output logic [7:0]        MapperType,
    output logic [2:0]        MapperFamily,
    output logic [8:0]        RomBankMask,
    output logic [3:0]        RamBankMask,
    output logic              HasRam,
    output logic              HasBattery,
    output logic              HasRtc,
    output logic [1:0]        CgbMode
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DECODE, S_FIN, S_ERR} state_t;

    localparam int               TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [ADDR_W-1:0] ADDR_CGB  = ADDR_W'('h143);
    localparam logic [ADDR_W-1:0] ADDR_TYPE = ADDR_W'('h147);
    localparam logic [ADDR_W-1:0] ADDR_ROM  = ADDR_W'('h148);
    localparam logic [ADDR_W-1:0] ADDR_RAM  = ADDR_W'('h149);
`ifdef GBC_HEADER_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] ADDR_CSUM  = ADDR_W'('h14D);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'('h134);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'('h14D);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'('h143);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'('h149);
`endif

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       cgb_q;
    logic [7:0]       type_q;
    logic [7:0]       rom_q;
    logic [7:0]       ram_q;
`ifdef GBC_HEADER_CHECKSUM_EN
    logic [7:0]       acc;
`endif

    logic [2:0] fam_c;
    logic       unsup_c;
    logic       bat_c;
    logic       rtc_c;
    logic       ram_c;
    logic       rom_bad_c;
    logic       ram_bad_c;
    logic [9:0] rom_wide;
    logic [8:0] rom_mask_c;
    logic [3:0] ram_mask_c;
    logic [1:0] cgb_c;

    // Decode of the captured raw bytes; registered into the outputs in S_DECODE.
    always_comb begin
        fam_c   = 3'd7;
        unsup_c = 1'b0;
        case (type_q)
            8'h00, 8'h08, 8'h09:                       fam_c = 3'd0;
            8'h01, 8'h02, 8'h03:                       fam_c = 3'd1;
            8'h05, 8'h06:                              fam_c = 3'd2;
            8'h0F, 8'h10, 8'h11, 8'h12, 8'h13:         fam_c = 3'd3;
            8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E:  fam_c = 3'd5;
            default:                                   unsup_c = 1'b1;
        endcase

        bat_c = type_q inside {8'h03, 8'h06, 8'h09, 8'h0F, 8'h10, 8'h13, 8'h1B, 8'h1E};
        rtc_c = (type_q == 8'h0F) || (type_q == 8'h10);
        ram_c = (type_q inside {8'h02, 8'h03, 8'h08, 8'h09, 8'h10, 8'h12, 8'h13,
                                8'h1A, 8'h1B, 8'h1D, 8'h1E}) || (fam_c == 3'd2);

        rom_bad_c  = (rom_q > 8'd8);
        rom_wide   = (10'd2 << rom_q[3:0]) - 10'd1;
        rom_mask_c = rom_bad_c ? 9'h1FF : rom_wide[8:0];

        ram_mask_c = 4'h0;
        ram_bad_c  = 1'b0;
        case (ram_q)
            8'h00, 8'h01, 8'h02: ram_mask_c = 4'h0;
            8'h03:               ram_mask_c = 4'h3;
            8'h04:               ram_mask_c = 4'hF;
            8'h05:               ram_mask_c = 4'h7;
            default:             ram_bad_c  = 1'b1;
        endcase

        cgb_c = cgb_q[1] ? (cgb_q[0] ? 2'd2 : 2'd1) : 2'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            cgb_q        <= '0;
            type_q       <= '0;
            rom_q        <= '0;
            ram_q        <= '0;
`ifdef GBC_HEADER_CHECKSUM_EN
            acc          <= '0;
`endif
            ReadReq      <= 1'b0;
            ReadAddr     <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            ChecksumOk   <= 1'b0;
            MapperType   <= '0;
            MapperFamily <= '0;
            RomBankMask  <= '0;
            RamBankMask  <= '0;
            HasRam       <= 1'b0;
            HasBattery   <= 1'b0;
            HasRtc       <= 1'b0;
            CgbMode      <= '0;
        end else if (ClkEn) begin
            case (state)
                S_IDLE, S_FIN, S_ERR: begin
                    if (Start) begin
                        state      <= S_REQ;
                        Busy       <= 1'b1;
                        Done       <= 1'b0;
                        Error      <= 1'b0;
                        ChecksumOk <= 1'b0;
                        ReadAddr   <= FIRST_ADDR;
`ifdef GBC_HEADER_CHECKSUM_EN
                        acc        <= '0;
`endif
                    end
                end
                // Address is already stable here; the request rises on the way out.
                S_REQ: begin
                    ReadReq <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (ReadAck) begin
                        if (ReadAddr == ADDR_CGB)  cgb_q  <= ReadData[7:6];
                        if (ReadAddr == ADDR_TYPE) type_q <= ReadData;
                        if (ReadAddr == ADDR_ROM)  rom_q  <= ReadData;
                        if (ReadAddr == ADDR_RAM)  ram_q  <= ReadData;
`ifdef GBC_HEADER_CHECKSUM_EN
                        if (ReadAddr == ADDR_CSUM) ChecksumOk <= (acc == ReadData);
                        else                       acc <= acc - ReadData - 8'd1;
`endif
                        ReadReq <= 1'b0;
                        if (ReadAddr == LAST_ADDR) begin
                            state <= S_DECODE;
                        end else begin
                            ReadAddr <= ReadAddr + ADDR_W'(1);
                            state    <= S_REQ;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        ReadReq <= 1'b0;
                        Error   <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    MapperType   <= type_q;
                    MapperFamily <= fam_c;
                    HasRam       <= ram_c;
                    HasBattery   <= bat_c;
                    HasRtc       <= rtc_c;
                    RomBankMask  <= rom_mask_c;
                    RamBankMask  <= ram_mask_c;
                    CgbMode      <= cgb_c;
                    Error        <= unsup_c | rom_bad_c | ram_bad_c;
`ifndef GBC_HEADER_CHECKSUM_EN
                    ChecksumOk   <= 1'b1;
`endif
                    Done         <= 1'b1;
                    Busy         <= 1'b0;
                    state        <= S_FIN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gbc_header_parser.sv
// Self-checking bench for gbc_header_parser: randomized header images and ack timing against a spec-level model.
module tb_gbc_header_parser;

`ifdef GBC_HEADER_CHECKSUM_EN
    localparam int NBYTES = 26;
    localparam bit CSUM   = 1'b1;
`else
    localparam int NBYTES = 7;
    localparam bit CSUM   = 1'b0;
`endif
    localparam int TMO    = 8;
    localparam int RST_AT = (NBYTES > 12) ? 10 : 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ClkEn = 1'b1;
    logic        Start = 1'b0;
    logic        ReadReq;
    logic [22:0] ReadAddr;
    logic        ReadAck = 1'b0;
    logic [7:0]  ReadData = 8'h00;
    logic        Busy, Done, Error, ChecksumOk;
    logic [7:0]  MapperType;
    logic [2:0]  MapperFamily;
    logic [8:0]  RomBankMask;
    logic [3:0]  RamBankMask;
    logic        HasRam, HasBattery, HasRtc;
    logic [1:0]  CgbMode;

    gbc_header_parser #(.ADDR_W(23), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .Start(Start),
        .ReadReq(ReadReq), .ReadAddr(ReadAddr), .ReadAck(ReadAck), .ReadData(ReadData),
        .Busy(Busy), .Done(Done), .Error(Error), .ChecksumOk(ChecksumOk),
        .MapperType(MapperType), .MapperFamily(MapperFamily),
        .RomBankMask(RomBankMask), .RamBankMask(RamBankMask),
        .HasRam(HasRam), .HasBattery(HasBattery), .HasRtc(HasRtc), .CgbMode(CgbMode)
    );

    always #5 Clk = ~Clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] img [0:25];             // header bytes $0134..$014D
    int         ram_tab [6] = '{0, 0, 0, 3, 15, 7};
    bit         en_rnd = 1'b0;
    bit         rnd_dly = 1'b0;
    bit         ack_en = 1'b1;
    int         dly = 0;
    int         ack_count = 0;
    int         stab_err = 0;
    logic       prev_req = 1'b0;
    logic [22:0] prev_addr = '0;

    wire [31:0] obs = {MapperFamily, HasRam, HasBattery, HasRtc, RomBankMask, RamBankMask,
                       CgbMode, Error, ChecksumOk, MapperType, Done};

    always @(negedge Clk) ClkEn = en_rnd ? 1'($urandom_range(0, 1)) : 1'b1;

    // Memory target: one ack per request after a programmable number of enabled cycles.
    always begin
        @(posedge Clk); #1;
        if (!Reset_n) begin
            ReadAck = 1'b0;
        end else begin
            if (ReadAck && ClkEn) begin
                ReadAck = 1'b0;
                ack_count++;
            end
            if (ReadReq && prev_req && ReadAddr !== prev_addr) stab_err++;
            if (ReadReq && !ReadAck && ack_en) begin
                if (dly == 0) begin
                    ReadAck  = 1'b1;
                    ReadData = img[int'(ReadAddr) - 'h134];
                    dly      = rnd_dly ? int'($urandom_range(0, 3)) : 0;
                end else if (ClkEn) begin
                    dly--;
                end
            end
        end
        prev_req  = ReadReq;
        prev_addr = ReadAddr;
    end

    function automatic logic [31:0] model_word();
        logic [7:0] t, cg, rc, mc;
        logic [2:0] fam;
        logic       hr, hb, ht, err, ck;
        logic [3:0] mm;
        logic [1:0] cm;
        int         rm, s;
        cg = img['h0F]; t = img['h13]; rc = img['h14]; mc = img['h15];
        if (t inside {8'h00, 8'h08, 8'h09})   fam = 3'd0;
        else if (t inside {[8'h01:8'h03]})    fam = 3'd1;
        else if (t inside {8'h05, 8'h06})     fam = 3'd2;
        else if (t inside {[8'h0F:8'h13]})    fam = 3'd3;
        else if (t inside {[8'h19:8'h1E]})    fam = 3'd5;
        else                                  fam = 3'd7;
        hb = t inside {8'h03, 8'h06, 8'h09, 8'h0F, 8'h10, 8'h13, 8'h1B, 8'h1E};
        ht = t inside {8'h0F, 8'h10};
        hr = (t inside {8'h02, 8'h03, 8'h08, 8'h09, 8'h10, 8'h12, 8'h13, 8'h1A, 8'h1B, 8'h1D, 8'h1E})
             || (fam == 3'd2);
        rm = (rc <= 8) ? ((2 << rc) - 1) : 511;
        mm = (mc <= 5) ? 4'(ram_tab[mc]) : 4'h0;
        cm = cg[7] ? (cg[6] ? 2'd2 : 2'd1) : 2'd0;
        err = (fam == 3'd7) || (rc > 8) || (mc > 5);
        if (CSUM) begin
            s = 0;
            for (int i = 0; i < 25; i++) s += int'(img[i]) + 1;
            ck = (8'((25600 - s) % 256) == img[25]);
        end else begin
            ck = 1'b1;
        end
        return {fam, hr, hb, ht, 9'(rm), mm, cm, err, ck, t, 1'b1};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 26; i++) img[i] = 8'h00;
    endtask

    task automatic set_csum(input bit good);
        int s = 0;
        for (int i = 0; i < 25; i++) s += int'(img[i]) + 1;
        img[25] = good ? 8'((25600 - s) % 256) : 8'((25601 - s) % 256);
    endtask

    // Start held until an enabled edge samples it; then count enabled edges until Done or Error.
    task automatic parse(output int cyc, output bit tmo);
        @(posedge Clk); #1;
        Start = 1'b1;
        do begin @(posedge Clk); #1; end while (!ClkEn);
        Start = 1'b0;
        cyc = 1;
        while (!(Done || Error) && cyc < 3000) begin
            @(posedge Clk); #1;
            if (ClkEn) cyc++;
        end
        tmo = !(Done || Error);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({ReadReq, ReadAddr, Busy, obs} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got %h required 0", {ReadReq, ReadAddr, Busy, obs});
        end
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({ReadReq, ReadAddr, Busy, obs} !== '0) begin
            failures++;
            $display("FAIL reset_release: got %h required 0", {ReadReq, ReadAddr, Busy, obs});
        end
    endtask

    task automatic test_mbc3(input bit good_csum);
        int cyc;
        bit tmo;
        clear_img();
        img['h13] = 8'h13; img['h14] = 8'h05; img['h15] = 8'h03;
        img[25] = good_csum ? 8'hCC : 8'hCD;
        parse(cyc, tmo);
        checks++;
        if (obs !== model_word()) begin
            failures++;
            $display("FAIL mbc3_model(csum_good=%0d): got %h required %h", good_csum, obs, model_word());
        end
        checks++;
        if ({MapperFamily, HasRam, HasBattery, HasRtc, RomBankMask, RamBankMask, ChecksumOk, Done}
            !== {3'd3, 1'b1, 1'b1, 1'b0, 9'h03F, 4'h3, (good_csum || !CSUM), 1'b1}) begin
            failures++;
            $display("FAIL mbc3_fields(csum_good=%0d): fam=%0d ram=%0d bat=%0d rtc=%0d rom=%h rammask=%h ck=%0d done=%0d",
                     good_csum, MapperFamily, HasRam, HasBattery, HasRtc, RomBankMask, RamBankMask, ChecksumOk, Done);
        end
        if (good_csum) begin
            checks++;
            if (cyc !== 2 * NBYTES + 2 || tmo) begin
                failures++;
                $display("FAIL done_latency: got %0d cycles required %0d", cyc, 2 * NBYTES + 2);
            end
            checks++;
            if (Busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_done: got %0d required 0", Busy);
            end
        end
    endtask

    task automatic test_unsupported();
        int cyc;
        bit tmo;
        clear_img();
        img['h13] = 8'h20; img['h14] = 8'h01;
        set_csum(1'b1);
        parse(cyc, tmo);
        checks++;
        if ({MapperFamily, Error, Done} !== {3'd7, 1'b1, 1'b1} || obs !== model_word()) begin
            failures++;
            $display("FAIL unsupported: got %h required %h (fam 7, err 1, done 1)", obs, model_word());
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit tmo;
        for (int r = 0; r < 2; r++) begin
            en_rnd = (r == 1);
            ack_en = 1'b0;
            parse(cyc, tmo);
            checks++;
            if (cyc !== TMO + 2) begin
                failures++;
                $display("FAIL timeout_cycles(clken_rnd=%0d): got %0d required %0d", r, cyc, TMO + 2);
            end
            checks++;
            if ({ReadReq, Done, Busy, Error} !== 4'b0001) begin
                failures++;
                $display("FAIL timeout_flags(clken_rnd=%0d): req/done/busy/err got %b required 0001",
                         r, {ReadReq, Done, Busy, Error});
            end
        end
        ack_en = 1'b1;
        en_rnd = 1'b0;
    endtask

    task automatic test_random();
        int         cyc;
        bit         tmo;
        logic [7:0] types [19] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0F,
                                   8'h10, 8'h11, 8'h12, 8'h13, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E};
        en_rnd   = 1'b1;
        rnd_dly  = 1'b1;
        stab_err = 0;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 26; i++) img[i] = 8'($urandom);
            img['h13] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : types[$urandom_range(0, 18)];
            img['h14] = 8'($urandom_range(0, 9));
            img['h15] = 8'($urandom_range(0, 6));
            if (it == 0) img['h0F] = 8'hC0;
            set_csum($urandom_range(0, 1) == 1);
            parse(cyc, tmo);
            checks++;
            if (tmo || obs !== model_word()) begin
                failures++;
                $display("FAIL random_parse[%0d]: got %h required %h stalled=%0d", it, obs, model_word(), tmo);
            end
            if (it == 0) begin
                checks++;
                if (CgbMode !== 2'd2) begin
                    failures++;
                    $display("FAIL cgb_only: got %0d required 2", CgbMode);
                end
            end
        end
        checks++;
        if (stab_err !== 0) begin
            failures++;
            $display("FAIL addr_stable: got %0d changes under ReadReq required 0", stab_err);
        end
        en_rnd  = 1'b0;
        rnd_dly = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc, k, base;
        bit tmo;
        clear_img();
        img['h0F] = 8'h80; img['h13] = 8'h1B; img['h14] = 8'h03; img['h15] = 8'h04;
        set_csum(1'b1);
        base = ack_count;
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        k = 0;
        while (ack_count < base + RST_AT && k < 500) begin
            @(posedge Clk); #2;
            k++;
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (k >= 500 || {ReadReq, ReadAddr, Busy, obs} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got %h required 0 (wait=%0d)", {ReadReq, ReadAddr, Busy, obs}, k);
        end
        @(negedge Clk) Reset_n = 1'b1;
        parse(cyc, tmo);
        checks++;
        if (obs !== model_word()) begin
            failures++;
            $display("FAIL restart_parse: got %h required %h", obs, model_word());
        end
        checks++;
        if (cyc !== 2 * NBYTES + 2 || tmo) begin
            failures++;
            $display("FAIL restart_latency: got %0d required %0d", cyc, 2 * NBYTES + 2);
        end
    endtask

    initial begin
        clear_img();
        test_reset();
        test_mbc3(1'b1);
        test_mbc3(1'b0);
        test_unsupported();
        test_timeout();
        test_random();
        test_reset_mid();
        test_mbc3(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gbc_header_parser.md
# gbc_header_parser

Reads the cartridge header from the loaded ROM image and produces the registered configuration word that the GBC mapper consumes: mapper family, bank masks, battery/RTC flags and CGB mode. It sits between the image loader's memory port and the mapper. It runs once per cartridge load, before the CPU leaves reset. It optionally validates the header checksum.

## Interface
Parameters:
- ADDR_W, 23, byte-address width of the image read port
- TIMEOUT, 255, enabled cycles to wait for ReadAck before aborting

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- ClkEn  in  1  clock enable; all state advances only when high
- Start  in  1  single-cycle pulse; begin parsing
- ReadReq  out  1  read request, held until ReadAck
- ReadAddr  out  ADDR_W  byte address, stable while ReadReq is high
- ReadAck  in  1  read complete; ReadData valid this cycle
- ReadData  in  8  returned byte
- Busy  out  1  parse in progress
- Done  out  1  sticky; parse finished, cleared by Start
- Error  out  1  sticky; timeout or unsupported type, cleared by Start
- ChecksumOk  out  1  header checksum matched
- MapperType  out  8  raw byte $0147
- MapperFamily  out  3  0 ROM, 1 MBC1, 2 MBC2, 3 MBC3, 5 MBC5, 7 unsupported
- RomBankMask  out  9  (2 << romsize) - 1
- RamBankMask  out  4  RAM bank mask
- HasRam, HasBattery, HasRtc  out  1 each  decoded from $0147
- CgbMode  out  2  0 DMG, 1 CGB+DMG ($80), 2 CGB-only ($C0)

## Operation
- States: IDLE, REQ, WAIT, DECODE, FIN, ERR.
- IDLE: Start moves to REQ, clears Done/Error/ChecksumOk, zeroes the accumulator, and sets the address to the first header byte. Start is ignored in any other state except FIN/ERR, where it restarts the parse.
- REQ/WAIT: ReadReq is held high. On ReadAck:
  - latch ReadData into the field selected by the address ($0143, $0147, $0148, $0149);
  - for $0134..$014C, update acc = acc - byte - 1 (mod 256);
  - at $014D, ChecksumOk = (acc == byte).
- After ReadAck, increment the address and re-enter REQ until the last byte, then enter DECODE.
- Only one read is outstanding at a time. ReadAddr never changes while ReadReq is high.
- DECODE, one cycle, computes the mapper family and flags from $0147:
  - family:
    - $00/$08/$09 → ROM
    - $01–$03 → MBC1
    - $05/$06 → MBC2
    - $0F–$13 → MBC3
    - $19–$1E → MBC5
    - else → 7, and Error is set
  - HasBattery: $03 $06 $09 $0F $10 $13 $1B $1E
  - HasRtc: $0F $10
  - HasRam: $02 $03 $08 $09 $10 $12 $13 $1A $1B $1D $1E, or MBC2
- RomBankMask: romsize codes 0–8 give 2<<code minus 1. Codes above 8 give $1FF and set Error.
- RamBankMask: $0149 code 0/1 → 0, 2 → 0, 3 → 3, 4 → $F, 5 → 7; other codes → 0 with Error set. A mask of 0 with HasRam means one bank.
- CgbMode: bit 7 of $0143 set and bit 6 set → 2; bit 7 set only → 1; else 0.
- FIN: Done=1 and Busy=0. Output fields hold until the next Start.
- Timeout: TIMEOUT enabled cycles in WAIT without ReadAck → ERR, with ReadReq dropped and Error=1.

## Timing
- Reset values: all outputs 0, MapperFamily 0, state IDLE.
- Start is sampled on an enabled cycle. ReadReq rises on the next enabled cycle.
- ReadAck may arrive in the first enabled cycle ReadReq is seen high (zero wait). Each byte then costs 2 enabled cycles.
- With a zero-wait target, Done rises 2N+2 enabled cycles after Start, where N = 26 with checksum (N = 7 without).
- ReadAck while ReadReq is low is ignored.
- ClkEn low freezes all state, including the timeout counter.
- Reset_n asserted mid-parse returns to IDLE immediately and drops ReadReq asynchronously. Any partial fields are discarded.

## Configuration
- GBC_HEADER_CHECKSUM_EN defined: the parse covers $0134..$014D (26 reads), as described above.
- Not defined: the parse covers only $0143..$0149 (7 reads), no accumulator is built, and ChecksumOk is driven to 1 on entry to FIN.

## Test plan
- Header of all zeros except $0147=$13, $0148=$05, $0149=$03, $014D=$CC, zero-wait ack → MapperFamily 3, HasRam=HasBattery=1, HasRtc=0, RomBankMask $03F, RamBankMask $3, ChecksumOk 1, Done at cycle 54.
- Same image with $014D=$CD → Done=1, ChecksumOk=0, all other fields identical.
- $0147=$20 → MapperFamily 7, Error=1, Done=1.
- Target never acks, TIMEOUT=8 → Error after 8 enabled cycles of WAIT, ReadReq=0, Done=0.
- Random 0–3 cycle ack delays, ClkEn toggling 50%, $0143=$C0 → CgbMode 2, ReadAddr stable under every held ReadReq.
- Reset_n pulsed at byte 10, then Start → outputs zero after reset, and a full correct parse on restart.
